// File: rtl/led_phase_scheduler.sv
// Time-multiplexes the optical front end through RED, IR and ambient phases.
// Each phase settles, then averages ADC samples. One result set is published per frame.
module led_phase_scheduler #(
    parameter int SETTLE_CYC = 2,
    parameter int ACC_LOG2   = 2,
    parameter int DARK_EN    = 1
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] RED_DC_Comp_in,
    input  logic [6:0] IR_DC_Comp_in,
    input  logic [3:0] RED_PGA_in,
    input  logic [3:0] IR_PGA_in,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] AMB_ADC_Value,
    output logic       sample_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, RED_SET, RED_ACQ, IR_SET, IR_ACQ, DRK_SET, DRK_ACQ, PUBLISH
    } state_t;

    localparam int         ACC_W    = 8 + ACC_LOG2;
    localparam logic [4:0] SET_LAST = 5'(SETTLE_CYC - 1);
    localparam logic [4:0] ACQ_LAST = 5'((1 << ACC_LOG2) - 1);

    function automatic logic [7:0] avg_trunc(input logic [ACC_W-1:0] sum);
        return 8'(sum >> ACC_LOG2);
    endfunction

    state_t             state, state_nx;
    logic [4:0]         cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [6:0]         lat_red_dc, lat_ir_dc;
    logic [3:0]         lat_red_pga, lat_ir_pga;
    logic [7:0]         red_avg, ir_avg, amb_avg;
    logic [7:0]         red_nx, ir_nx, amb_nx, avg_now;
    logic               set_done, acq_done, frame_start, in_acq;
    logic [6:0]         use_red_dc, use_ir_dc;
    logic [3:0]         use_red_pga, use_ir_pga;
    logic               led_red_d, led_ir_d;
    logic [6:0]         dc_d;
    logic [3:0]         pga_d;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        set_done = (cnt == SET_LAST);
        acq_done = (cnt == ACQ_LAST);
        unique case (state)
            IDLE:    if (enable)   state_nx = RED_SET;
            RED_SET: if (set_done) state_nx = RED_ACQ;
            RED_ACQ: if (acq_done) state_nx = IR_SET;
            IR_SET:  if (set_done) state_nx = IR_ACQ;
            IR_ACQ:  if (acq_done) state_nx = (DARK_EN != 0) ? DRK_SET : PUBLISH;
            DRK_SET: if (set_done) state_nx = DRK_ACQ;
            DRK_ACQ: if (acq_done) state_nx = PUBLISH;
            PUBLISH: state_nx = enable ? RED_SET : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Settings are sampled only at frame start; outputs are registered from the next state,
    // so the fresh settings are forwarded on the frame-start edge itself.
    always_comb begin
        frame_start = (state == IDLE || state == PUBLISH) && (state_nx == RED_SET);
        in_acq      = (state == RED_ACQ) || (state == IR_ACQ) || (state == DRK_ACQ);
        acc_sum     = acc + ACC_W'(ADC);
        avg_now     = avg_trunc(acc_sum);
        use_red_dc  = frame_start ? RED_DC_Comp_in : lat_red_dc;
        use_ir_dc   = frame_start ? IR_DC_Comp_in  : lat_ir_dc;
        use_red_pga = frame_start ? RED_PGA_in     : lat_red_pga;
        use_ir_pga  = frame_start ? IR_PGA_in      : lat_ir_pga;
        red_nx      = (state == RED_ACQ && acq_done) ? avg_now : red_avg;
        ir_nx       = (state == IR_ACQ  && acq_done) ? avg_now : ir_avg;
        amb_nx      = (state == DRK_ACQ && acq_done) ? avg_now : amb_avg;
        led_red_d   = 1'b0;
        led_ir_d    = 1'b0;
        dc_d        = 7'd0;
        pga_d       = 4'd0;
        unique case (state_nx)
            RED_SET, RED_ACQ: begin
                led_red_d = 1'b1;
                dc_d      = use_red_dc;
                pga_d     = use_red_pga;
            end
            IR_SET, IR_ACQ: begin
                led_ir_d  = 1'b1;
                dc_d      = use_ir_dc;
                pga_d     = use_ir_pga;
            end
            DRK_SET, DRK_ACQ: begin
                dc_d      = use_red_dc;
                pga_d     = use_red_pga;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= 5'd0;
            acc           <= '0;
            lat_red_dc    <= 7'd0;
            lat_ir_dc     <= 7'd0;
            lat_red_pga   <= 4'd0;
            lat_ir_pga    <= 4'd0;
            red_avg       <= 8'd0;
            ir_avg        <= 8'd0;
            amb_avg       <= 8'd0;
            LED_RED       <= 1'b0;
            LED_IR        <= 1'b0;
            DC_Comp       <= 7'd0;
            PGA_Gain      <= 4'd0;
            RED_ADC_Value <= 8'd0;
            IR_ADC_Value  <= 8'd0;
            AMB_ADC_Value <= 8'd0;
            sample_valid  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            cnt <= (state_nx != state) ? 5'd0 : cnt + 5'd1;
            acc <= (in_acq && !acq_done) ? acc_sum : '0;
            if (frame_start) begin
                lat_red_dc  <= RED_DC_Comp_in;
                lat_ir_dc   <= IR_DC_Comp_in;
                lat_red_pga <= RED_PGA_in;
                lat_ir_pga  <= IR_PGA_in;
            end
            red_avg  <= red_nx;
            ir_avg   <= ir_nx;
            amb_avg  <= amb_nx;
            LED_RED  <= led_red_d;
            LED_IR   <= led_ir_d;
            DC_Comp  <= dc_d;
            PGA_Gain <= pga_d;
            if (state_nx == PUBLISH) begin
                RED_ADC_Value <= red_nx;
                IR_ADC_Value  <= ir_nx;
                AMB_ADC_Value <= (DARK_EN != 0) ? amb_nx : 8'd0;
            end
            sample_valid <= (state_nx == PUBLISH);
            busy         <= (state_nx != IDLE);
        end
    end

endmodule
